// File: rtl/lsu_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_byte_sequencer
// Brief    : Serialises byte/halfword/word loads and stores onto an 8-bit
//            memory port, little-endian, with load assembly and extension.
//            Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_byte_sequencer #(
    parameter int ADDRESS_LINE = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_LINE-1:0] req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_error,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [7:0]              mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDRESS_LINE-1:0] r_addr;
    logic [1:0]              r_size;
    logic                    r_write;
    logic                    r_unsigned;
    logic                    r_error;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [1:0]              r_idx;
    logic [1:0]              r_last_idx;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic [1:0]              w_last_idx;
    logic                    w_last_byte;
    logic                    w_in_access;
    logic [31:0]             w_load_ext;

    assign w_accept = req_valid & (r_state == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = ((req_size == 2'd1) & req_addr[0]) |
                          ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_illegal   = (req_size == 2'd3) | w_misaligned;
    assign w_last_byte = (r_idx == r_last_idx);
    assign w_in_access = (r_state == S_ACCESS);

    always_comb begin
        w_last_idx = 2'd3;
        case (req_size)
            2'd0:    w_last_idx = 2'd0;
            2'd1:    w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_illegal ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_last_byte) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_error    <= 1'b0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_idx      <= 2'd0;
            r_last_idx <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_error    <= w_illegal;
                r_wdata    <= req_wdata;
                r_rdata    <= 32'd0;
                r_idx      <= 2'd0;
                r_last_idx <= w_last_idx;
            end else if (w_in_access) begin
                r_idx <= r_idx + 2'd1;
                if (!r_write) begin
                    r_rdata[{r_idx, 3'b000} +: 8] <= mem_read_data;
                end
            end
        end
    end

    always_comb begin
        w_load_ext = r_rdata;
        case (r_size)
            2'd0:    w_load_ext = {{24{~r_unsigned & r_rdata[7]}},  r_rdata[7:0]};
            2'd1:    w_load_ext = {{16{~r_unsigned & r_rdata[15]}}, r_rdata[15:0]};
            default: w_load_ext = r_rdata;
        endcase
    end

    // Enables are masked by reset so that a reset landing mid-access stops
    // the byte in flight from being committed at the reset edge.
    always_comb begin
        req_ready      = (r_state == S_IDLE);
        resp_valid     = (r_state == S_DONE);
        resp_error     = (r_state == S_DONE) & r_error;
        resp_rdata     = 32'd0;
        mem_address    = '0;
        mem_write_data = 8'd0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if ((r_state == S_DONE) && !r_error && !r_write) begin
            resp_rdata = w_load_ext;
        end
        if (w_in_access) begin
            mem_address = r_addr + ADDRESS_LINE'(r_idx);
            mem_write   = r_write & ~reset;
            mem_read    = ~r_write & ~reset;
            if (r_write) begin
                mem_write_data = r_wdata[{r_idx, 3'b000} +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_byte_sequencer
// Brief    : Directed scoreboard bench for lsu_byte_sequencer with a byte
//            memory model; honours LSU_MISALIGN_TRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_byte_sequencer;

    localparam int ADDRESS_LINE = 16;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic                    req_write = 1'b0;
    logic [1:0]              req_size = 2'd0;
    logic                    req_unsigned = 1'b0;
    logic [ADDRESS_LINE-1:0] req_addr = '0;
    logic [31:0]             req_wdata = 32'd0;
    logic                    resp_valid;
    logic [31:0]             resp_rdata;
    logic                    resp_error;
    logic [ADDRESS_LINE-1:0] mem_address;
    logic [7:0]              mem_write_data;
    logic                    mem_write;
    logic                    mem_read;
    logic [7:0]              mem_read_data;

    lsu_byte_sequencer #(.ADDRESS_LINE(ADDRESS_LINE)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;

    // Byte memory: preload port has priority, reads are combinational.
    logic [7:0]  mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [7:0]  pre_data = 8'd0;

    always @(posedge clock) begin
        if (pre_en)         mem[pre_addr]    <= pre_data;
        else if (mem_write) mem[mem_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    logic [32:0] exp_q [$];
    string       name_q [$];

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [32:0] e;
        string       nm;
        forever begin
            @(negedge clock);
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (mem_read && mem_write)
                check(1'b0, "rd_wr_overlap", {30'd0, mem_read, mem_write}, 32'd0);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check(resp_error == e[32], {nm, "_err"}, {31'd0, resp_error}, {31'd0, e[32]});
                    check(resp_rdata == e[31:0], {nm, "_rdata"}, resp_rdata, e[31:0]);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clock);
        #1 pre_en = 1'b0;
    endtask

    task automatic mem_check(input logic [15:0] a, input logic [7:0] d, input string name);
        check(mem[a] === d, name, {24'd0, mem[a]}, {24'd0, d});
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat, input string name);
        int  cyc;
        bit  seen;
        cyc = 0;
        @(negedge clock);
        while (!req_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check(req_ready, {name, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        exp_q.push_back({exp_err, exp_rd});
        name_q.push_back(name);
        @(posedge clock);
        // Scramble the request after the accept edge; the DUT must have latched it.
        #1;
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_size     = 2'd3;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = 32'hDEADBEEF;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) seen = 1'b1;
        end
        check(seen && (cyc == exp_lat), {name, "_latency"}, cyc, exp_lat);
        @(negedge clock);
        check(req_ready, {name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int rd0;
        int wr0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check(req_ready == 1'b1,   "reset_ready",  {31'd0, req_ready},  32'd1);
        check(resp_valid == 1'b0,  "reset_valid",  {31'd0, resp_valid}, 32'd0);
        check(resp_rdata == 32'd0, "reset_rdata",  resp_rdata, 32'd0);
        check((mem_read | mem_write | resp_error) == 1'b0, "reset_enables",
              {29'd0, mem_read, mem_write, resp_error}, 32'd0);
        check(mem_address == '0,   "reset_addr",   {16'd0, mem_address}, 32'd0);

        // Word store, then read it back as a word.
        wr0 = wr_cnt;
        do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hA1B2C3D4, 1'b0, 32'd0, 5, "sw_0010");
        check(wr_cnt - wr0 == 4, "sw_0010_wr_cycles", wr_cnt - wr0, 4);
        mem_check(16'h0010, 8'hD4, "sw_0010_b0");
        mem_check(16'h0011, 8'hC3, "sw_0010_b1");
        mem_check(16'h0012, 8'hB2, "sw_0010_b2");
        mem_check(16'h0013, 8'hA1, "sw_0010_b3");
        do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 1'b0, 32'hA1B2C3D4, 5, "lw_0010");

        // Byte loads with sign and zero extension.
        preload(16'h0030, 8'h85);
        do_req(1'b0, 2'd0, 1'b0, 16'h0030, 32'd0, 1'b0, 32'hFFFFFF85, 2, "lb_s");
        do_req(1'b0, 2'd0, 1'b1, 16'h0030, 32'd0, 1'b0, 32'h00000085, 2, "lb_u");

        // Halfword loads.
        preload(16'h0020, 8'h34);
        preload(16'h0021, 8'h92);
        rd0 = rd_cnt;
        do_req(1'b0, 2'd1, 1'b0, 16'h0020, 32'd0, 1'b0, 32'hFFFF9234, 3, "lh_s");
        check(rd_cnt - rd0 == 2, "lh_s_rd_cycles", rd_cnt - rd0, 2);
        do_req(1'b0, 2'd1, 1'b1, 16'h0020, 32'd0, 1'b0, 32'h00009234, 3, "lh_u");

        // Byte and halfword stores read back.
        do_req(1'b1, 2'd0, 1'b0, 16'h0040, 32'h1234565A, 1'b0, 32'd0, 2, "sb_0040");
        mem_check(16'h0040, 8'h5A, "sb_0040_b0");
        do_req(1'b1, 2'd1, 1'b0, 16'h0042, 32'h99887766, 1'b0, 32'd0, 3, "sh_0042");
        do_req(1'b0, 2'd1, 1'b0, 16'h0042, 32'd0, 1'b0, 32'h00007766, 3, "lh_0042");

        // Word store straddling the top of the address space.
        preload(16'hFFFE, 8'h00);
        preload(16'hFFFF, 8'h00);
        preload(16'h0000, 8'h00);
        preload(16'h0001, 8'h00);
        wr0 = wr_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344, 1'b1, 32'd0, 1, "sw_wrap");
        check(wr_cnt - wr0 == 0, "sw_wrap_wr_cycles", wr_cnt - wr0, 0);
        mem_check(16'hFFFE, 8'h00, "sw_wrap_b0");
        mem_check(16'h0001, 8'h00, "sw_wrap_b3");
`else
        do_req(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344, 1'b0, 32'd0, 5, "sw_wrap");
        check(wr_cnt - wr0 == 4, "sw_wrap_wr_cycles", wr_cnt - wr0, 4);
        mem_check(16'hFFFE, 8'h44, "sw_wrap_b0");
        mem_check(16'hFFFF, 8'h33, "sw_wrap_b1");
        mem_check(16'h0000, 8'h22, "sw_wrap_b2");
        mem_check(16'h0001, 8'h11, "sw_wrap_b3");
`endif

        // Reserved size: error, no memory traffic.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_req(1'b0, 2'd3, 1'b0, 16'h0030, 32'd0, 1'b1, 32'd0, 1, "size3_ld");
        do_req(1'b1, 2'd3, 1'b0, 16'h0030, 32'hFFFFFFFF, 1'b1, 32'd0, 1, "size3_st");
        check((rd_cnt - rd0) + (wr_cnt - wr0) == 0, "size3_mem_cycles",
              (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        mem_check(16'h0030, 8'h85, "size3_mem_intact");

        // Reset during cycle 2 of a word store.
        preload(16'h0050, 8'h00);
        preload(16'h0051, 8'h00);
        preload(16'h0052, 8'h00);
        preload(16'h0053, 8'h00);
        wr0 = wr_cnt;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 16'h0050;
        req_wdata = 32'hCAFEBABE;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check(req_ready == 1'b1,  "rst_mid_ready", {31'd0, req_ready},  32'd1);
        check(resp_valid == 1'b0, "rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        repeat (4) @(negedge clock);
        check(wr_cnt - wr0 == 1, "rst_mid_wr_cycles", wr_cnt - wr0, 1);
        mem_check(16'h0050, 8'hBE, "rst_mid_b0");
        mem_check(16'h0051, 8'h00, "rst_mid_b1");
        mem_check(16'h0052, 8'h00, "rst_mid_b2");
        mem_check(16'h0053, 8'h00, "rst_mid_b3");

        // Sequencer is fully usable after the mid-access reset.
        do_req(1'b0, 2'd0, 1'b1, 16'h0050, 32'd0, 1'b0, 32'h000000BE, 2, "lb_after_rst");

        repeat (2) @(negedge clock);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
